hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It consumes the decode-stage register fields that the ID/EX register latches. It keeps its own registered shadow of the EX, MEM and WB destination fields, and from that shadow it drives the ID/EX `clr`, the IF/ID stall and flush, and the EX operand forwarding selects. It also counts stall cycles for performance reporting.

---
 rtl/hazard_unit_pkg.sv | 33 +++
 rtl/hazard_fwd_sel.sv | 21 ++
 rtl/hazard_unit.sv | 98 +++++++++
 tb/tb_hazard_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// rtl/hazard_unit_pkg.sv - shared encodings and stage-record types for the hazard controller
package hazard_unit_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_IMM = 2'b11;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic       reg_write;
        logic [4:0] rd;
        logic       is_load;
    } stage_rec_t;

    typedef struct packed {
        stage_rec_t rec;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } ex_rec_t;

    localparam stage_rec_t STAGE_BUBBLE = '0;
    localparam ex_rec_t    EX_BUBBLE    = '0;

    // x0 is hardwired to zero, so a record targeting it never produces a hazard.
    function automatic logic rec_writes(input stage_rec_t rec);
        return rec.reg_write && (rec.rd != 5'd0);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - priority comparator selecting the EX operand source
module hazard_fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic [4:0] rs,
    input  stage_rec_t mem_rec,
    input  stage_rec_t wb_rec,
    output logic [1:0] sel
);

    // MEM is checked first: it holds the younger write of the same register.
    always_comb begin
        sel = FWD_RF;
        if (rec_writes(mem_rec) && (mem_rec.rd == rs)) begin
            sel = FWD_MEM;
        end else if (rec_writes(wb_rec) && (wb_rec.rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - load-use stall, redirect flush and EX forwarding control
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [1:0] LOAD_SRC = RES_MEM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             useRs1D,
    input  logic             useRs2D,
    input  logic             regWriteD,
    input  logic [1:0]       resultSrcD,
    input  logic             pcSrcE,
    output logic             stallF,
    output logic             stallD,
    output logic             flushD,
    output logic             flushE,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic [CNT_W-1:0] stallCount
);

    ex_rec_t    ex_q;
    stage_rec_t mem_q;
    stage_rec_t wb_q;

    ex_rec_t    ex_next;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       lw_stall;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    always_comb begin
        ex_next               = EX_BUBBLE;
        ex_next.rec.reg_write = regWriteD;
        ex_next.rec.rd        = RdD;
        ex_next.rec.is_load   = (resultSrcD == LOAD_SRC);
        ex_next.rs1           = useRs1D ? Rs1D : 5'd0;
        ex_next.rs2           = useRs2D ? Rs2D : 5'd0;
    end

    always_comb begin
        rs1_hit  = useRs1D && (Rs1D == ex_q.rec.rd);
        rs2_hit  = useRs2D && (Rs2D == ex_q.rec.rd);
        lw_stall = rec_writes(ex_q.rec) && ex_q.rec.is_load && (rs1_hit || rs2_hit);
    end

    hazard_fwd_sel u_fwd_a (
        .rs      (ex_q.rs1),
        .mem_rec (mem_q),
        .wb_rec  (wb_q),
        .sel     (fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .rs      (ex_q.rs2),
        .mem_rec (mem_q),
        .wb_rec  (wb_q),
        .sel     (fwd_b)
    );

    // A redirect squashes the stalled instruction anyway, so it overrides the stall.
    // Reset forces both flushes so nothing leaks into the pipeline while held.
    always_comb begin
        stallF    = rst_n && lw_stall && !pcSrcE;
        stallD    = stallF;
        flushD    = !rst_n || pcSrcE;
        flushE    = !rst_n || lw_stall || pcSrcE;
        forwardAE = rst_n ? fwd_a : FWD_RF;
        forwardBE = rst_n ? fwd_b : FWD_RF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= EX_BUBBLE;
            mem_q <= STAGE_BUBBLE;
            wb_q  <= STAGE_BUBBLE;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q.rec;
            ex_q  <= flushE ? EX_BUBBLE : ex_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCount <= '0;
        end else if (stallD && (stallCount != {CNT_W{1'b1}})) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed vector bench for hazard_unit
module tb_hazard_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  Rs1D, Rs2D, RdD;
    logic        useRs1D, useRs2D, regWriteD;
    logic [1:0]  resultSrcD;
    logic        pcSrcE;

    logic        stallF, stallD, flushD, flushE;
    logic [1:0]  forwardAE, forwardBE;
    logic [15:0] stallCount;

    logic        stallF4, stallD4, flushD4, flushE4;
    logic [1:0]  forwardAE4, forwardBE4;
    logic [3:0]  stallCount4;

    int checks = 0;
    int failures = 0;

    hazard_unit dut (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .useRs1D(useRs1D), .useRs2D(useRs2D), .regWriteD(regWriteD),
        .resultSrcD(resultSrcD), .pcSrcE(pcSrcE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .forwardAE(forwardAE), .forwardBE(forwardBE), .stallCount(stallCount)
    );

    hazard_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .useRs1D(useRs1D), .useRs2D(useRs2D), .regWriteD(regWriteD),
        .resultSrcD(resultSrcD), .pcSrcE(pcSrcE),
        .stallF(stallF4), .stallD(stallD4), .flushD(flushD4), .flushE(flushE4),
        .forwardAE(forwardAE4), .forwardBE(forwardBE4), .stallCount(stallCount4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, rw;
        logic [1:0] rsrc;
        logic       pc;
        logic       st, fd, fe;
        logic [1:0] fa, fb;
        int         cnt;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(input int rs1, rs2, rd, u1, u2, rw, rsrc, pc,
                                input int st, fd, fe, fa, fb, cnt);
        vec_t v;
        v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.rd = 5'(rd);
        v.u1 = 1'(u1); v.u2 = 1'(u2); v.rw = 1'(rw);
        v.rsrc = 2'(rsrc); v.pc = 1'(pc);
        v.st = 1'(st); v.fd = 1'(fd); v.fe = 1'(fe);
        v.fa = 2'(fa); v.fb = 2'(fb); v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs1, rs2, rd, input logic u1, u2, rw,
                         input logic [1:0] rsrc, input logic pc);
        Rs1D = rs1; Rs2D = rs2; RdD = rd;
        useRs1D = u1; useRs2D = u2; regWriteD = rw;
        resultSrcD = rsrc; pcSrcE = pc;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_stallF"}, stallF, 0);
        chk({tag, "_stallD"}, stallD, 0);
        chk({tag, "_flushD"}, flushD, 1);
        chk({tag, "_flushE"}, flushE, 1);
        chk({tag, "_fwdA"}, forwardAE, 0);
        chk({tag, "_fwdB"}, forwardBE, 0);
        chk({tag, "_cnt"}, stallCount, 0);
        chk({tag, "_cnt4"}, stallCount4, 0);
    endtask

    initial begin
        // rs1 rs2 rd u1 u2 rw rsrc pc | st fd fe fa fb cnt
        vecs[0]  = mk(1, 0, 5,  1, 0, 1, 1, 0,  0, 0, 0, 0, 0, 0); // lw x5
        vecs[1]  = mk(5, 1, 6,  1, 1, 1, 0, 0,  1, 0, 1, 0, 0, 0); // add x6,x5,x1 stalls
        vecs[2]  = mk(5, 1, 6,  1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1); // held add, bubble in E
        vecs[3]  = mk(1, 2, 3,  1, 1, 1, 0, 0,  0, 0, 0, 1, 0, 1); // add x6 in EX: A from WB
        vecs[4]  = mk(3, 3, 4,  1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1); // sub x4,x3,x3
        vecs[5]  = mk(0, 0, 7,  1, 0, 1, 0, 0,  0, 0, 0, 2, 2, 1); // sub in EX: both from MEM
        vecs[6]  = mk(0, 0, 7,  1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[7]  = mk(7, 7, 8,  1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[8]  = mk(1, 0, 0,  1, 0, 1, 1, 0,  0, 0, 0, 2, 2, 1); // x7 reader: MEM wins
        vecs[9]  = mk(0, 0, 9,  1, 0, 1, 0, 0,  0, 0, 0, 0, 0, 1); // lw x0 then x0 reader
        vecs[10] = mk(2, 0, 10, 1, 0, 1, 1, 0,  0, 0, 0, 0, 0, 1); // lw x10
        vecs[11] = mk(10, 0, 11, 1, 0, 1, 0, 1, 0, 1, 1, 0, 0, 1); // stall + redirect
        vecs[12] = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);
        vecs[13] = mk(3, 0, 12, 1, 0, 1, 0, 1,  0, 1, 1, 0, 0, 1); // redirect alone
        vecs[14] = mk(0, 0, 0,  0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 1);

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
        #2;
        chk_reset_outs("reset");
        #10 rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
                  vecs[i].rw, vecs[i].rsrc, vecs[i].pc);
            #1;
            chk($sformatf("v%0d_stallF", i), stallF, vecs[i].st);
            chk($sformatf("v%0d_stallD", i), stallD, vecs[i].st);
            chk($sformatf("v%0d_flushD", i), flushD, vecs[i].fd);
            chk($sformatf("v%0d_flushE", i), flushE, vecs[i].fe);
            chk($sformatf("v%0d_fwdA", i), forwardAE, vecs[i].fa);
            chk($sformatf("v%0d_fwdB", i), forwardBE, vecs[i].fb);
            chk($sformatf("v%0d_cnt", i), stallCount, vecs[i].cnt);
        end

        // Reset dropped asynchronously in the middle of a load-use stall.
        @(negedge clk);
        drive(0, 0, 5, 1, 0, 1, 2'b01, 0);
        @(negedge clk);
        drive(5, 0, 6, 1, 0, 1, 2'b00, 0);
        #1;
        chk("pre_rst_stallD", stallD, 1);
        chk("pre_rst_cnt", stallCount, 1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 2'b00, 0);
        #1 rst_n = 1'b1;
        #1;
        chk("post_rst_flushD", flushD, 0);
        chk("post_rst_flushE", flushE, 0);

        // lw x5,0(x5) held in decode stalls on every other edge.
        @(negedge clk);
        drive(5, 0, 5, 1, 0, 1, 2'b01, 0);
        repeat (28) @(posedge clk);
        #1;
        chk("sat_cnt4_14", stallCount4, 14);
        repeat (2) @(posedge clk);
        #1;
        chk("sat_cnt4_15", stallCount4, 15);
        repeat (10) @(posedge clk);
        #1;
        chk("sat_cnt4_hold", stallCount4, 15);
        chk("sat_cnt16_20", stallCount, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
